cbus_clint: RTL

Memory-mapped core-local interruptor (CLINT) that answers CBus requests as a responder, the same side of the bus as the RAM helper. It sits behind the CBus arbiter on an address-decoded port. It owns the machine timer (mtime/mtimecmp) and the software-interrupt bit (msip), and drives the core's trint and swint inputs.

---
 rtl/common.sv | 43 ++++
 rtl/clint_timer.sv | 71 +++++++
 rtl/cbus_clint.sv | 121 ++++++++++++
 3 files changed

// File: rtl/common.sv
// Shared CBus types plus CLINT register offsets and handshake states.
// Imported by cbus_clint and clint_timer.
package common;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

    localparam logic [15:0] CLINT_MSIP_OFF     = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] CLINT_MTIME_OFF    = 16'hBFF8;

    typedef enum logic [1:0] {
        IDLE,
        BEAT,
        DONE
    } clint_state_t;

    function automatic logic [63:0] apply_strobe(input logic [63:0] old_val,
                                                 input logic [63:0] wdata,
                                                 input logic [7:0]  strobe);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++) begin
            if (strobe[i]) res[8*i +: 8] = wdata[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/clint_timer.sv
// Machine timer: mtime, mtimecmp, optional prescaler and the registered trint.
// Prescaler present only when CLINT_PRESCALE_EN is defined.
module clint_timer
    import common::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mtime_we,
    input  logic        i_mtimecmp_we,
    input  logic [7:0]  i_strobe,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_mtime,
    output logic [63:0] o_mtimecmp,
    output logic        o_trint
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_trint;
    logic [63:0] w_mtime_inc;
    logic [63:0] w_mtime_d;
    logic [63:0] w_mtimecmp_d;
    logic        w_tick;

`ifdef CLINT_PRESCALE_EN
    logic [15:0] r_presc;
    logic [15:0] w_presc_d;

    always_comb begin
        w_tick    = (r_presc == 16'(TICK_DIV - 1));
        w_presc_d = w_tick ? 16'd0 : r_presc + 16'd1;
        // A software write to mtime restarts the tick period.
        if (i_mtime_we) w_presc_d = 16'd0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_presc <= 16'd0;
        else        r_presc <= w_presc_d;
    end
`else
    logic [15:0] w_unused_div;
    assign w_unused_div = 16'(TICK_DIV);
    assign w_tick       = 1'b1;
`endif

    always_comb begin
        w_mtime_inc  = r_mtime + {63'd0, w_tick};
        // Written bytes win over the tick; unwritten bytes keep the increment.
        w_mtime_d    = i_mtime_we ? apply_strobe(w_mtime_inc, i_wdata, i_strobe) : w_mtime_inc;
        w_mtimecmp_d = i_mtimecmp_we ? apply_strobe(r_mtimecmp, i_wdata, i_strobe) : r_mtimecmp;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= '1;
            r_trint    <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_d;
            r_mtimecmp <= w_mtimecmp_d;
            r_trint    <= (w_mtime_d >= w_mtimecmp_d);
        end
    end

    assign o_mtime    = r_mtime;
    assign o_mtimecmp = r_mtimecmp;
    assign o_trint    = r_trint;

endmodule

// File: rtl/cbus_clint.sv
// CBus responder CLINT: handshake FSM, address decode and msip; timer lives in clint_timer.
// Optional feature macro: CLINT_PRESCALE_EN (mtime prescaler in clint_timer).
module cbus_clint
    import common::*;
#(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [63:0] BASE     = 64'h0200_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  oreq,
    output cbus_resp_t oresp,
    output logic       trint,
    output logic       swint
);

    clint_state_t r_state, w_state_d;
    logic [63:0]  r_addr, w_addr_d;
    logic [7:0]   r_len, w_len_d;
    logic [7:0]   r_cnt, w_cnt_d;
    logic         r_is_write, w_is_write_d;
    logic         r_msip, w_msip_d;
    logic         r_swint;

    logic         w_in_win;
    logic         w_sel_msip;
    logic         w_sel_mtimecmp;
    logic         w_sel_mtime;
    logic         w_wr;
    logic [63:0]  w_rdata;
    logic [63:0]  w_mtime;
    logic [63:0]  w_mtimecmp;
    logic         w_unused;

    assign w_unused = ^{oreq.size, oreq.burst, oreq.addr[2:0]};

    assign w_in_win       = (r_addr[63:16] == BASE[63:16]);
    assign w_sel_msip     = w_in_win && (r_addr[15:0] == CLINT_MSIP_OFF);
    assign w_sel_mtimecmp = w_in_win && (r_addr[15:0] == CLINT_MTIMECMP_OFF);
    assign w_sel_mtime    = w_in_win && (r_addr[15:0] == CLINT_MTIME_OFF);
    assign w_wr           = (r_state == BEAT) && r_is_write;

    always_comb begin
        w_rdata = 64'd0;
        if (w_sel_msip)          w_rdata = {63'd0, r_msip};
        else if (w_sel_mtimecmp) w_rdata = w_mtimecmp;
        else if (w_sel_mtime)    w_rdata = w_mtime;
    end

    always_comb begin
        w_state_d    = r_state;
        w_addr_d     = r_addr;
        w_len_d      = r_len;
        w_cnt_d      = r_cnt;
        w_is_write_d = r_is_write;
        oresp        = '0;
        unique case (r_state)
            IDLE: begin
                if (oreq.valid) begin
                    w_addr_d     = {oreq.addr[63:3], 3'b000};
                    w_len_d      = oreq.len;
                    w_is_write_d = oreq.is_write;
                    w_cnt_d      = 8'd0;
                    w_state_d    = BEAT;
                end
            end
            BEAT: begin
                oresp.ready = 1'b1;
                oresp.data  = w_rdata;
                oresp.last  = (r_cnt == r_len);
                w_addr_d    = r_addr + 64'd8;
                w_cnt_d     = r_cnt + 8'd1;
                if (r_cnt == r_len) w_state_d = DONE;
            end
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_comb begin
        w_msip_d = r_msip;
        if (w_wr && w_sel_msip && oreq.strobe[0]) w_msip_d = oreq.data[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_addr     <= 64'd0;
            r_len      <= 8'd0;
            r_cnt      <= 8'd0;
            r_is_write <= 1'b0;
            r_msip     <= 1'b0;
            r_swint    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_addr     <= w_addr_d;
            r_len      <= w_len_d;
            r_cnt      <= w_cnt_d;
            r_is_write <= w_is_write_d;
            r_msip     <= w_msip_d;
            r_swint    <= w_msip_d;
        end
    end

    clint_timer #(
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .i_mtime_we    (w_wr && w_sel_mtime),
        .i_mtimecmp_we (w_wr && w_sel_mtimecmp),
        .i_strobe      (oreq.strobe),
        .i_wdata       (oreq.data),
        .o_mtime       (w_mtime),
        .o_mtimecmp    (w_mtimecmp),
        .o_trint       (trint)
    );

    assign swint = r_swint;

endmodule
